// File: rtl/al_accel_pkg.sv
// rtl/al_accel_pkg.sv - shared widths, conv direction codes and data typedefs for the AL accelerator PU array
package al_accel_pkg;

  localparam int DW = 8;
  localparam int AW = 20;

  typedef enum logic [1:0] {
    NON   = 2'b00,
    LEFT  = 2'b01,
    RIGHT = 2'b10,
    DOWN  = 2'b11
  } conv_dir_e;

  typedef logic signed [DW-1:0] pixel_t;
  typedef logic signed [DW-1:0] weight_t;
  typedef logic signed [AW-1:0] acc_t;

endpackage

// File: rtl/al_accel_pu.sv
// rtl/al_accel_pu.sv - one processing unit: 3x3 kernel, serial 9-step MAC (ReLU via AL_ACCEL_PU_RELU_EN)
module al_accel_pu #(
  parameter int DW = 8,
  parameter int AW = 20
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [2:0]           wreg_enb_i,
  input  logic [8:0][DW-1:0]   wdi_i,
  input  logic [8:0][DW-1:0]   win_i,
  input  logic                 pu_enb_i,
  output logic [AW-1:0]        odo_o,
  output logic                 odv_o
);

  logic [8:0][DW-1:0] w_q;
  logic [3:0]         step_q;
  logic [AW-1:0]      acc_q;
  logic [AW-1:0]      odo_q;
  logic               odv_q;

  logic [DW-1:0]        w_sel;
  logic [DW-1:0]        x_sel;
  logic signed [2*DW-1:0] w_ext;
  logic signed [2*DW-1:0] x_ext;
  logic signed [2*DW-1:0] prod;
  logic [AW-1:0]        prod_ext;
  logic [AW-1:0]        sum;
  logic [AW-1:0]        result;

  // Operands are sign-extended to the product width so the truncated multiply is exact.
  always_comb begin
    w_sel    = w_q[step_q];
    x_sel    = win_i[step_q];
    w_ext    = {{DW{w_sel[DW-1]}}, w_sel};
    x_ext    = {{DW{x_sel[DW-1]}}, x_sel};
    prod     = w_ext * x_ext;
    prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
    sum      = ((step_q == 4'd0) ? '0 : acc_q) + prod_ext;
`ifdef AL_ACCEL_PU_RELU_EN
    result   = sum[AW-1] ? '0 : sum;
`else
    result   = sum;
`endif
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      w_q    <= '0;
      step_q <= '0;
      acc_q  <= '0;
      odo_q  <= '0;
      odv_q  <= 1'b0;
    end else begin
      for (int r = 0; r < 3; r++) begin
        if (wreg_enb_i[r]) begin
          for (int c = 0; c < 3; c++) begin
            w_q[r*3+c] <= wdi_i[r*3+c];
          end
        end
      end
      odv_q <= 1'b0;
      if (pu_enb_i) begin
        if (step_q == 4'd8) begin
          step_q <= '0;
          odo_q  <= result;
          odv_q  <= 1'b1;
        end else begin
          step_q <= step_q + 4'd1;
          acc_q  <= sum;
        end
      end
    end
  end

  assign odo_o = odo_q;
  assign odv_o = odv_q;

endmodule

// File: rtl/al_accel_pu_array_3x3.sv
// rtl/al_accel_pu_array_3x3.sv - three PUs sharing one sliding 3x3 window (PU ReLU via AL_ACCEL_PU_RELU_EN)
module al_accel_pu_array_3x3 #(
  parameter int DW = al_accel_pkg::DW,
  parameter int AW = al_accel_pkg::AW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [DW-1:0] pu_arr_wdi_0_0_0, pu_arr_wdi_0_0_1, pu_arr_wdi_0_0_2,
  input  logic [DW-1:0] pu_arr_wdi_0_1_0, pu_arr_wdi_0_1_1, pu_arr_wdi_0_1_2,
  input  logic [DW-1:0] pu_arr_wdi_0_2_0, pu_arr_wdi_0_2_1, pu_arr_wdi_0_2_2,
  input  logic [DW-1:0] pu_arr_wdi_1_0_0, pu_arr_wdi_1_0_1, pu_arr_wdi_1_0_2,
  input  logic [DW-1:0] pu_arr_wdi_1_1_0, pu_arr_wdi_1_1_1, pu_arr_wdi_1_1_2,
  input  logic [DW-1:0] pu_arr_wdi_1_2_0, pu_arr_wdi_1_2_1, pu_arr_wdi_1_2_2,
  input  logic [DW-1:0] pu_arr_wdi_2_0_0, pu_arr_wdi_2_0_1, pu_arr_wdi_2_0_2,
  input  logic [DW-1:0] pu_arr_wdi_2_1_0, pu_arr_wdi_2_1_1, pu_arr_wdi_2_1_2,
  input  logic [DW-1:0] pu_arr_wdi_2_2_0, pu_arr_wdi_2_2_1, pu_arr_wdi_2_2_2,
  input  logic [DW-1:0] pu_arr_idi_0_0, pu_arr_idi_0_1, pu_arr_idi_0_2,
  input  logic [DW-1:0] pu_arr_idi_1_0, pu_arr_idi_1_1, pu_arr_idi_1_2,
  input  logic [DW-1:0] pu_arr_idi_2_0, pu_arr_idi_2_1, pu_arr_idi_2_2,
  input  logic          pu_arr_is_conv_layer,
  input  logic [1:0]    pu_arr_conv_dir,
  input  logic          wreg_enb_0_0, wreg_enb_0_1, wreg_enb_0_2,
  input  logic          wreg_enb_1_0, wreg_enb_1_1, wreg_enb_1_2,
  input  logic          wreg_enb_2_0, wreg_enb_2_1, wreg_enb_2_2,
  input  logic          ireg_enb_0, ireg_enb_1, ireg_enb_2,
  input  logic          pu_enb_0, pu_enb_1, pu_enb_2,
  output logic [AW-1:0] pu_arr_odo_0, pu_arr_odo_1, pu_arr_odo_2,
  output logic          pu_arr_odv_0, pu_arr_odv_1, pu_arr_odv_2
);

  import al_accel_pkg::*;

  logic [8:0][DW-1:0] idi;
  logic [8:0][DW-1:0] wdi [3];
  logic [2:0]         wenb [3];
  logic [2:0]         ienb;
  logic [2:0]         penb;
  logic [AW-1:0]      odo [3];
  logic [2:0]         odv;

  assign idi = {pu_arr_idi_2_2, pu_arr_idi_2_1, pu_arr_idi_2_0,
                pu_arr_idi_1_2, pu_arr_idi_1_1, pu_arr_idi_1_0,
                pu_arr_idi_0_2, pu_arr_idi_0_1, pu_arr_idi_0_0};
  assign wdi[0] = {pu_arr_wdi_0_2_2, pu_arr_wdi_0_2_1, pu_arr_wdi_0_2_0,
                   pu_arr_wdi_0_1_2, pu_arr_wdi_0_1_1, pu_arr_wdi_0_1_0,
                   pu_arr_wdi_0_0_2, pu_arr_wdi_0_0_1, pu_arr_wdi_0_0_0};
  assign wdi[1] = {pu_arr_wdi_1_2_2, pu_arr_wdi_1_2_1, pu_arr_wdi_1_2_0,
                   pu_arr_wdi_1_1_2, pu_arr_wdi_1_1_1, pu_arr_wdi_1_1_0,
                   pu_arr_wdi_1_0_2, pu_arr_wdi_1_0_1, pu_arr_wdi_1_0_0};
  assign wdi[2] = {pu_arr_wdi_2_2_2, pu_arr_wdi_2_2_1, pu_arr_wdi_2_2_0,
                   pu_arr_wdi_2_1_2, pu_arr_wdi_2_1_1, pu_arr_wdi_2_1_0,
                   pu_arr_wdi_2_0_2, pu_arr_wdi_2_0_1, pu_arr_wdi_2_0_0};
  assign wenb[0] = {wreg_enb_0_2, wreg_enb_0_1, wreg_enb_0_0};
  assign wenb[1] = {wreg_enb_1_2, wreg_enb_1_1, wreg_enb_1_0};
  assign wenb[2] = {wreg_enb_2_2, wreg_enb_2_1, wreg_enb_2_0};
  assign ienb    = {ireg_enb_2, ireg_enb_1, ireg_enb_0};
  assign penb    = {pu_enb_2, pu_enb_1, pu_enb_0};

  logic [8:0][DW-1:0] x_q;
  logic [8:0][DW-1:0] x_d;
  logic [8:0][DW-1:0] below;
  conv_dir_e          dir;
  logic               full_load;

  assign dir       = conv_dir_e'(pu_arr_conv_dir);
  assign full_load = !pu_arr_is_conv_layer || (dir == NON);
  // For DOWN each row takes the row beneath it; the bottom row takes the row-0 shift-in pixels.
  assign below     = {idi[2:0], x_q[8:3]};

  always_comb begin
    x_d = x_q;
    for (int r = 0; r < 3; r++) begin
      if (ienb[r]) begin
        if (full_load) begin
          for (int c = 0; c < 3; c++) x_d[r*3+c] = idi[r*3+c];
        end else begin
          case (dir)
            LEFT: begin
              x_d[r*3]   = x_q[r*3+1];
              x_d[r*3+1] = x_q[r*3+2];
              x_d[r*3+2] = idi[r];
            end
            RIGHT: begin
              x_d[r*3+2] = x_q[r*3+1];
              x_d[r*3+1] = x_q[r*3];
              x_d[r*3]   = idi[r];
            end
            default: begin
              for (int c = 0; c < 3; c++) x_d[r*3+c] = below[r*3+c];
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) x_q <= '0;
    else        x_q <= x_d;
  end

  for (genvar p = 0; p < 3; p++) begin : g_pu
    al_accel_pu #(.DW(DW), .AW(AW)) u_pu (
      .clk        (clk),
      .resetn     (resetn),
      .wreg_enb_i (wenb[p]),
      .wdi_i      (wdi[p]),
      .win_i      (x_q),
      .pu_enb_i   (penb[p]),
      .odo_o      (odo[p]),
      .odv_o      (odv[p])
    );
  end

  assign pu_arr_odo_0 = odo[0];
  assign pu_arr_odo_1 = odo[1];
  assign pu_arr_odo_2 = odo[2];
  assign pu_arr_odv_0 = odv[0];
  assign pu_arr_odv_1 = odv[1];
  assign pu_arr_odv_2 = odv[2];

endmodule

// File: tb/tb_al_accel_pu_array_3x3.sv
// tb/tb_al_accel_pu_array_3x3.sv - directed and random checks of the PU array against a behavioural model
module tb_al_accel_pu_array_3x3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetn;
  logic signed [7:0] wdi [3][3][3];
  logic signed [7:0] idi [3][3];
  logic              is_conv;
  logic [1:0]        dir;
  logic              wenb [3][3];
  logic              ienb [3];
  logic              penb [3];
  logic signed [19:0] odo [3];
  logic              odv [3];

  int mw [3][3][3];
  int mx [3][3];
  int macc [3];
  int mstep [3];
  int modo [3];
  int modv [3];
  int tests = 0;
  int fails = 0;

  al_accel_pu_array_3x3 dut (
    .clk(clk), .resetn(resetn),
    .pu_arr_wdi_0_0_0(wdi[0][0][0]), .pu_arr_wdi_0_0_1(wdi[0][0][1]), .pu_arr_wdi_0_0_2(wdi[0][0][2]),
    .pu_arr_wdi_0_1_0(wdi[0][1][0]), .pu_arr_wdi_0_1_1(wdi[0][1][1]), .pu_arr_wdi_0_1_2(wdi[0][1][2]),
    .pu_arr_wdi_0_2_0(wdi[0][2][0]), .pu_arr_wdi_0_2_1(wdi[0][2][1]), .pu_arr_wdi_0_2_2(wdi[0][2][2]),
    .pu_arr_wdi_1_0_0(wdi[1][0][0]), .pu_arr_wdi_1_0_1(wdi[1][0][1]), .pu_arr_wdi_1_0_2(wdi[1][0][2]),
    .pu_arr_wdi_1_1_0(wdi[1][1][0]), .pu_arr_wdi_1_1_1(wdi[1][1][1]), .pu_arr_wdi_1_1_2(wdi[1][1][2]),
    .pu_arr_wdi_1_2_0(wdi[1][2][0]), .pu_arr_wdi_1_2_1(wdi[1][2][1]), .pu_arr_wdi_1_2_2(wdi[1][2][2]),
    .pu_arr_wdi_2_0_0(wdi[2][0][0]), .pu_arr_wdi_2_0_1(wdi[2][0][1]), .pu_arr_wdi_2_0_2(wdi[2][0][2]),
    .pu_arr_wdi_2_1_0(wdi[2][1][0]), .pu_arr_wdi_2_1_1(wdi[2][1][1]), .pu_arr_wdi_2_1_2(wdi[2][1][2]),
    .pu_arr_wdi_2_2_0(wdi[2][2][0]), .pu_arr_wdi_2_2_1(wdi[2][2][1]), .pu_arr_wdi_2_2_2(wdi[2][2][2]),
    .pu_arr_idi_0_0(idi[0][0]), .pu_arr_idi_0_1(idi[0][1]), .pu_arr_idi_0_2(idi[0][2]),
    .pu_arr_idi_1_0(idi[1][0]), .pu_arr_idi_1_1(idi[1][1]), .pu_arr_idi_1_2(idi[1][2]),
    .pu_arr_idi_2_0(idi[2][0]), .pu_arr_idi_2_1(idi[2][1]), .pu_arr_idi_2_2(idi[2][2]),
    .pu_arr_is_conv_layer(is_conv), .pu_arr_conv_dir(dir),
    .wreg_enb_0_0(wenb[0][0]), .wreg_enb_0_1(wenb[0][1]), .wreg_enb_0_2(wenb[0][2]),
    .wreg_enb_1_0(wenb[1][0]), .wreg_enb_1_1(wenb[1][1]), .wreg_enb_1_2(wenb[1][2]),
    .wreg_enb_2_0(wenb[2][0]), .wreg_enb_2_1(wenb[2][1]), .wreg_enb_2_2(wenb[2][2]),
    .ireg_enb_0(ienb[0]), .ireg_enb_1(ienb[1]), .ireg_enb_2(ienb[2]),
    .pu_enb_0(penb[0]), .pu_enb_1(penb[1]), .pu_enb_2(penb[2]),
    .pu_arr_odo_0(odo[0]), .pu_arr_odo_1(odo[1]), .pu_arr_odo_2(odo[2]),
    .pu_arr_odv_0(odv[0]), .pu_arr_odv_1(odv[1]), .pu_arr_odv_2(odv[2])
  );

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int relu(input int v);
`ifdef AL_ACCEL_PU_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic idle();
    for (int p = 0; p < 3; p++) begin
      penb[p] = 1'b0;
      ienb[p] = 1'b0;
      for (int r = 0; r < 3; r++) wenb[p][r] = 1'b0;
    end
  endtask

  // One clock edge: advance the model from the driven inputs, then compare every output.
  task automatic tick();
    int nx [3][3];
    int term;
    if (resetn) begin
      for (int p = 0; p < 3; p++) begin
        macc[p] = 0; mstep[p] = 0; modo[p] = 0; modv[p] = 0;
        for (int r = 0; r < 3; r++) begin
          mx[p][r] = 0;
          for (int c = 0; c < 3; c++) mw[p][r][c] = 0;
        end
      end
    end else begin
      for (int p = 0; p < 3; p++) begin
        modv[p] = 0;
        if (penb[p]) begin
          term = mw[p][mstep[p]/3][mstep[p]%3] * mx[mstep[p]/3][mstep[p]%3];
          macc[p] = (mstep[p] == 0) ? term : macc[p] + term;
          if (mstep[p] == 8) begin
            modo[p] = relu(macc[p]);
            modv[p] = 1;
            mstep[p] = 0;
          end else begin
            mstep[p]++;
          end
        end
        for (int r = 0; r < 3; r++)
          if (wenb[p][r]) for (int c = 0; c < 3; c++) mw[p][r][c] = int'(wdi[p][r][c]);
      end
      nx = mx;
      for (int r = 0; r < 3; r++) begin
        if (ienb[r]) begin
          if (!is_conv || dir == 2'b00) begin
            for (int c = 0; c < 3; c++) nx[r][c] = int'(idi[r][c]);
          end else if (dir == 2'b01) begin
            nx[r][0] = mx[r][1]; nx[r][1] = mx[r][2]; nx[r][2] = int'(idi[0][r]);
          end else if (dir == 2'b10) begin
            nx[r][0] = int'(idi[0][r]); nx[r][1] = mx[r][0]; nx[r][2] = mx[r][1];
          end else begin
            for (int c = 0; c < 3; c++) nx[r][c] = (r < 2) ? mx[r+1][c] : int'(idi[0][c]);
          end
        end
      end
      mx = nx;
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < 3; p++) begin
      check($sformatf("odo%0d", p), int'(odo[p]), modo[p]);
      check($sformatf("odv%0d", p), int'(odv[p]), modv[p]);
    end
  endtask

  task automatic load_window_full(input int base);
    is_conv = 1'b0; dir = 2'b00;
    for (int r = 0; r < 3; r++) begin
      ienb[r] = 1'b1;
      for (int c = 0; c < 3; c++) idi[r][c] = 8'(base + r*3 + c);
    end
    tick();
    idle();
  endtask

  task automatic load_weights_const(input int p, input int v);
    for (int r = 0; r < 3; r++) begin
      wenb[p][r] = 1'b1;
      for (int c = 0; c < 3; c++) wdi[p][r][c] = 8'(v);
    end
  endtask

  task automatic load_onehot(input int p, input int pos);
    for (int r = 0; r < 3; r++) begin
      wenb[p][r] = 1'b1;
      for (int c = 0; c < 3; c++) wdi[p][r][c] = (r*3+c == pos) ? 8'sd1 : 8'sd0;
    end
  endtask

  task automatic run_pus(input bit p0, input bit p1, input bit p2, input int n);
    for (int k = 0; k < n; k++) begin
      penb[0] = p0; penb[1] = p1; penb[2] = p2;
      tick();
    end
    idle();
  endtask

  initial begin
    resetn = 1'b1; is_conv = 1'b0; dir = 2'b00;
    for (int p = 0; p < 3; p++)
      for (int r = 0; r < 3; r++) begin
        idi[p][r] = 8'($urandom);
        for (int c = 0; c < 3; c++) wdi[p][r][c] = 8'($urandom_range(1, 100));
      end
    // Reset held for 3 cycles with every enable asserted.
    for (int p = 0; p < 3; p++) begin
      penb[p] = 1'b1; ienb[p] = 1'b1;
      for (int r = 0; r < 3; r++) wenb[p][r] = 1'b1;
    end
    repeat (3) tick();
    resetn = 1'b0;
    idle();
    tick();
    run_pus(1, 1, 1, 9);
    check("post_reset_zero_weights", int'(odo[0]), 0);

    // All weights 1, window 0..8: 36 on every PU.
    for (int p = 0; p < 3; p++) load_weights_const(p, 1);
    load_window_full(0);
    run_pus(1, 1, 1, 9);
    for (int p = 0; p < 3; p++) begin
      check($sformatf("sum36_pu%0d", p), int'(odo[p]), 36);
      check($sformatf("sum36_odv%0d", p), int'(odv[p]), 1);
    end
    tick();
    check("sum36_odv_single", int'(odv[0]), 0);

    // Signed extremes.
    load_weights_const(0, -128);
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) idi[r][c] = 8'sd127;
    for (int r = 0; r < 3; r++) ienb[r] = 1'b1;
    tick();
    idle();
    run_pus(1, 0, 0, 9);
`ifdef AL_ACCEL_PU_RELU_EN
    check("signed_min", int'(odo[0]), 0);
`else
    check("signed_min", int'(odo[0]), -146304);
`endif

    // LEFT shift of 1..9 with shift-in {10,11,12}; centre tap sees 6.
    load_onehot(1, 4);
    load_window_full(1);
    is_conv = 1'b1; dir = 2'b01;
    idi[0][0] = 8'sd10; idi[0][1] = 8'sd11; idi[0][2] = 8'sd12;
    for (int r = 0; r < 3; r++) ienb[r] = 1'b1;
    tick();
    idle();
    run_pus(0, 1, 0, 9);
    check("left_centre", int'(odo[1]), 6);

    // DOWN then RIGHT on a random window, probed at all nine positions.
    is_conv = 1'b0;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) idi[r][c] = 8'($urandom);
    for (int r = 0; r < 3; r++) ienb[r] = 1'b1;
    tick();
    is_conv = 1'b1; dir = 2'b11;
    for (int c = 0; c < 3; c++) idi[0][c] = 8'($urandom);
    tick();
    dir = 2'b10;
    for (int c = 0; c < 3; c++) idi[0][c] = 8'($urandom);
    tick();
    idle();
    for (int b = 0; b < 3; b++) begin
      for (int p = 0; p < 3; p++) load_onehot(p, b*3 + p);
      tick();
      idle();
      run_pus(1, 1, 1, 9);
    end

    // Pause after 4 steps for 3 cycles: result 36, odv on the 12th cycle.
    load_weights_const(0, 1);
    load_window_full(0);
    run_pus(1, 0, 0, 4);
    run_pus(0, 0, 0, 3);
    run_pus(1, 0, 0, 5);
    check("pause_sum", int'(odo[0]), 36);
    check("pause_odv", int'(odv[0]), 1);

    // Random traffic: concurrent loads, shifts and MACs with occasional reset.
    for (int k = 0; k < 300; k++) begin
      resetn  = ($urandom_range(0, 99) == 0);
      is_conv = 1'($urandom);
      dir     = 2'($urandom);
      for (int p = 0; p < 3; p++) begin
        penb[p] = ($urandom_range(0, 3) != 0);
        ienb[p] = ($urandom_range(0, 2) == 0);
        idi[p][0] = 8'($urandom); idi[p][1] = 8'($urandom); idi[p][2] = 8'($urandom);
        for (int r = 0; r < 3; r++) begin
          wenb[p][r] = ($urandom_range(0, 4) == 0);
          for (int c = 0; c < 3; c++) wdi[p][r][c] = 8'($urandom);
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
